img_frame_writer: RTL

- Source-side loader for the CORDIC image-rotation engine. Accepts a serial stream of 6-bit pixels over a valid/ready handshake and packs them into a 48-entry frame buffer.
- When the frame is complete, presents it as a flat bus, pulses start to the rotator, and holds the frame stable until the rotator reports done.
- Sits between the switch/key input logic (or a future UART pixel source) and the rotator. It is the writer for the rotated-image reader path.

---
 rtl/img_frame_writer.sv | 83 ++++++++
 1 files changed

// File: rtl/img_frame_writer.sv
// Packs a valid/ready pixel stream into a DEPTH-entry frame, then pulses start for the rotator.
// start rises one cycle after the last pixel is accepted; pix_ready stays low from launch until rot_done.
module img_frame_writer #(
  parameter int DEPTH  = 48,
  parameter int PIX_W  = 6,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     clear,
  output logic [DEPTH*PIX_W-1:0]   frame_flat,
  output logic                     start,
  input  logic                     rot_done,
  output logic                     busy,
  output logic [ADDR_W-1:0]        pix_count,
  output logic [7:0]               frame_cnt,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [PIX_W-1:0]         rd_data
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]             state;
  logic [DEPTH*PIX_W-1:0] frame_q;
  logic                   accept;

  assign pix_ready  = reset && (state == FILL);
  assign busy       = (state == LAUNCH) || (state == WAIT);
  assign accept     = pix_valid && pix_ready;
  assign frame_flat = frame_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      frame_q   <= '0;
      pix_count <= '0;
      frame_cnt <= '0;
      start     <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        FILL: begin
          // clear takes priority: a pixel presented alongside it is dropped
          if (clear) begin
            pix_count <= '0;
          end else if (accept) begin
            frame_q[int'(pix_count)*PIX_W +: PIX_W] <= pix_in;
            pix_count <= pix_count + ADDR_W'(1);
            if (pix_count == LAST_IDX) begin
              state <= LAUNCH;
              start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          frame_cnt <= frame_cnt + 8'd1;
          state     <= WAIT;
        end
        WAIT: begin
          if (rot_done) begin
            pix_count <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < DEPTH_EXT) rd_data = frame_q[int'(rd_addr)*PIX_W +: PIX_W];
  end

endmodule
